// File: rtl/hs_spi_slave_avmm.sv
// hs_spi_slave_avmm
// Quad-lane SPI responder. It decodes CMD/ADDR/DATA frames arriving on
// SCK/CSn/MOSI and turns each frame into one single-beat AVMM access. For reads,
// the returned word goes back out on MISO after a fixed dummy gap. The SPI pins
// are oversampled in aclk, so aclk must run at least 8x faster than SCK.
// Ports:
//   aclk, aresetn           clock and asynchronous active-low reset
//   SCK, CSn, MOSI          SPI pins (mode 0; MOSI carries the MSB lane first)
//   MISO, MISO_oe           read data lanes and their output enable
//   avm_*                   AVMM host interface (word address, single beat)
//   busy                    high from CSn fall until the FSM returns to IDLE
//   err_stb                 one-cycle pulse on a bad command or missing read data
module hs_spi_slave_avmm #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int SPI_W        = 4,
    parameter int DUMMY_CYCLES = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             SCK,
    input  logic             CSn,
    input  logic [SPI_W-1:0] MOSI,
    output logic [SPI_W-1:0] MISO,
    output logic             MISO_oe,
    output logic [AW-1:0]    avm_address,
    output logic             avm_read,
    output logic             avm_write,
    output logic [DW-1:0]    avm_writedata,
    output logic [DW/8-1:0]  avm_byteenable,
    input  logic [DW-1:0]    avm_readdata,
    input  logic             avm_readdatavalid,
    input  logic             avm_waitrequest,
    output logic             busy,
    output logic             err_stb
);
    localparam int             AF         = SPI_W * ((AW + SPI_W - 1) / SPI_W);
    localparam int             BCW        = 8;
    localparam logic [BCW-1:0] CMD_LAST   = BCW'(8 / SPI_W - 1);
    localparam logic [BCW-1:0] ADDR_LAST  = BCW'(AF / SPI_W - 1);
    localparam logic [BCW-1:0] DATA_LAST  = BCW'(DW / SPI_W - 1);
    localparam logic [BCW-1:0] DATA_BEATS = BCW'(DW / SPI_W);
    localparam logic [BCW-1:0] DUMMY_N    = BCW'(DUMMY_CYCLES);
    localparam logic [7:0]     CMD_WRITE  = 8'h02;
    localparam logic [7:0]     CMD_READ   = 8'h0B;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_WDATA  = 3'd3,
        S_WRITE  = 3'd4,
        S_RDUMMY = 3'd5,
        S_RDATA  = 3'd6,
        S_IGNORE = 3'd7
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sck_meta, r_sck_s, r_sck_d;
    logic             r_csn_meta, r_csn_s, r_csn_d;
    logic [SPI_W-1:0] r_mosi_meta, r_mosi_s;
    logic [BCW-1:0]   r_beat;
    logic [DW-1:0]    r_shift;
    logic [SPI_W-1:0] r_miso;
    logic             r_miso_oe, r_busy, r_err_stb, r_is_read, r_rd_have;
    logic             r_avm_read, r_avm_write;
    logic [AW-1:0]    r_avm_address;
    logic [DW-1:0]    r_avm_writedata;

    logic             w_rise, w_fall, w_sample, w_csn_fall;
    logic [DW-1:0]    w_shift_nxt, w_rd_word;
    logic             w_err, w_cmd_ok, w_addr_done, w_wdata_done, w_rd_load, w_rd_shift;

    // A beat only counts while CSn is still low, so a rise landing together with
    // the CSn rise is dropped.
    assign w_rise      = r_sck_s & ~r_sck_d;
    assign w_fall      = ~r_sck_s & r_sck_d;
    assign w_sample    = w_rise & ~r_csn_s;
    assign w_csn_fall  = ~r_csn_s & r_csn_d;
    assign w_shift_nxt = {r_shift[DW-SPI_W-1:0], r_mosi_s};
    // A word arriving on the same cycle as the RDATA entry fall still counts as captured.
    assign w_rd_word   = avm_readdatavalid ? avm_readdata
                       : (r_rd_have ? r_shift : {DW{1'b1}});

    // Two-flop synchronizers for the SPI pins, plus one delay stage for edge detection
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sck_meta  <= 1'b0;
            r_sck_s     <= 1'b0;
            r_sck_d     <= 1'b0;
            r_csn_meta  <= 1'b1;
            r_csn_s     <= 1'b1;
            r_csn_d     <= 1'b1;
            r_mosi_meta <= {SPI_W{1'b0}};
            r_mosi_s    <= {SPI_W{1'b0}};
        end else begin
            r_sck_meta  <= SCK;
            r_sck_s     <= r_sck_meta;
            r_sck_d     <= r_sck_s;
            r_csn_meta  <= CSn;
            r_csn_s     <= r_csn_meta;
            r_csn_d     <= r_csn_s;
            r_mosi_meta <= MOSI;
            r_mosi_s    <= r_mosi_meta;
        end
    end

    // FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and one-cycle control strobes; CSn high overrides every state
    always_comb begin
        w_state_nxt  = r_state;
        w_err        = 1'b0;
        w_cmd_ok     = 1'b0;
        w_addr_done  = 1'b0;
        w_wdata_done = 1'b0;
        w_rd_load    = 1'b0;
        w_rd_shift   = 1'b0;
        if ((r_state != S_IDLE) && r_csn_s) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_csn_fall) w_state_nxt = S_CMD;
                    else            w_state_nxt = S_IDLE;
                end
                S_CMD: begin
                    if (w_sample && (r_beat == CMD_LAST)) begin
                        if ((w_shift_nxt[7:0] == CMD_WRITE) || (w_shift_nxt[7:0] == CMD_READ)) begin
                            w_cmd_ok    = 1'b1;
                            w_state_nxt = S_ADDR;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = S_IGNORE;
                        end
                    end else begin
                        w_state_nxt = S_CMD;
                    end
                end
                S_ADDR: begin
                    if (w_sample && (r_beat == ADDR_LAST)) begin
                        w_addr_done = 1'b1;
                        w_state_nxt = r_is_read ? S_RDUMMY : S_WDATA;
                    end else begin
                        w_state_nxt = S_ADDR;
                    end
                end
                S_WDATA: begin
                    if (w_sample && (r_beat == DATA_LAST)) begin
                        w_wdata_done = 1'b1;
                        w_state_nxt  = S_WRITE;
                    end else begin
                        w_state_nxt = S_WDATA;
                    end
                end
                S_WRITE: begin
                    if (r_avm_write && !avm_waitrequest) w_state_nxt = S_IGNORE;
                    else                                 w_state_nxt = S_WRITE;
                end
                S_RDUMMY: begin
                    if (w_fall && (r_beat == DUMMY_N)) begin
                        w_rd_load   = 1'b1;
                        w_err       = ~(r_rd_have | avm_readdatavalid);
                        w_state_nxt = S_RDATA;
                    end else begin
                        w_state_nxt = S_RDUMMY;
                    end
                end
                S_RDATA: begin
                    if (w_fall) begin
                        if (r_beat == DATA_BEATS) w_state_nxt = S_IGNORE;
                        else                      w_rd_shift  = 1'b1;
                    end else begin
                        w_state_nxt = S_RDATA;
                    end
                end
                S_IGNORE: w_state_nxt = S_IGNORE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Beat counter: rises within a field. In RDATA it counts falls instead, and the entry fall counts as the first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_beat <= BCW'(0);
        end else if (w_state_nxt != r_state) begin
            r_beat <= w_rd_load ? BCW'(1) : BCW'(0);
        end else if (w_sample && ((r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_WDATA))) begin
            r_beat <= r_beat + BCW'(1);
        end else if (w_sample && (r_state == S_RDUMMY) && (r_beat < DUMMY_N)) begin
            r_beat <= r_beat + BCW'(1);
        end else if (w_rd_shift) begin
            r_beat <= r_beat + BCW'(1);
        end else begin
            r_beat <= r_beat;
        end
    end

    // Shared shift register: MOSI deserializer on the way in, read-data serializer on the way out
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_shift   <= {DW{1'b0}};
            r_rd_have <= 1'b0;
        end else begin
            if (w_sample && ((r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_WDATA))) begin
                r_shift <= w_shift_nxt;
            end else if (w_rd_load) begin
                r_shift <= w_rd_word << SPI_W;
            end else if (w_rd_shift) begin
                r_shift <= r_shift << SPI_W;
            end else if ((r_state == S_RDUMMY) && avm_readdatavalid) begin
                r_shift <= avm_readdata;
            end else begin
                r_shift <= r_shift;
            end
            r_rd_have <= (r_state == S_RDUMMY) & (r_rd_have | avm_readdatavalid);
        end
    end

    // MISO lanes plus the frame status outputs, all registered from the next state
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_miso    <= {SPI_W{1'b0}};
            r_miso_oe <= 1'b0;
            r_busy    <= 1'b0;
            r_err_stb <= 1'b0;
            r_is_read <= 1'b0;
        end else begin
            if (w_rd_load)                    r_miso <= w_rd_word[DW-1 -: SPI_W];
            else if (w_rd_shift)              r_miso <= r_shift[DW-1 -: SPI_W];
            else if (w_state_nxt != S_RDATA)  r_miso <= {SPI_W{1'b0}};
            else                              r_miso <= r_miso;
            r_miso_oe <= (w_state_nxt == S_RDUMMY) || (w_state_nxt == S_RDATA);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_err_stb <= w_err;
            if (w_cmd_ok) r_is_read <= (w_shift_nxt[7:0] == CMD_READ);
            else          r_is_read <= r_is_read;
        end
    end

    // AVMM requests sit outside the FSM so that an abort cannot drop an access still waiting on waitrequest
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_avm_read      <= 1'b0;
            r_avm_write     <= 1'b0;
            r_avm_address   <= {AW{1'b0}};
            r_avm_writedata <= {DW{1'b0}};
        end else begin
            if (w_addr_done)                       r_avm_address <= w_shift_nxt[AW-1:0];
            else                                   r_avm_address <= r_avm_address;
            if (w_wdata_done)                      r_avm_writedata <= w_shift_nxt;
            else                                   r_avm_writedata <= r_avm_writedata;
            if (w_addr_done && r_is_read)          r_avm_read <= 1'b1;
            else if (r_avm_read && !avm_waitrequest) r_avm_read <= 1'b0;
            else                                   r_avm_read <= r_avm_read;
            if (w_wdata_done)                      r_avm_write <= 1'b1;
            else if (r_avm_write && !avm_waitrequest) r_avm_write <= 1'b0;
            else                                   r_avm_write <= r_avm_write;
        end
    end

    assign MISO           = r_miso;
    assign MISO_oe        = r_miso_oe;
    assign busy           = r_busy;
    assign err_stb        = r_err_stb;
    assign avm_read       = r_avm_read;
    assign avm_write      = r_avm_write;
    assign avm_address    = r_avm_address;
    assign avm_writedata  = r_avm_writedata;
    assign avm_byteenable = {(DW/8){1'b1}};
endmodule

// File: tb/tb_hs_spi_slave_avmm.sv
// Bench for hs_spi_slave_avmm. A bench-side SPI master drives frames, a bench-side AVMM
// responder serves a memory, and expected AVMM accesses, read words and error pulses
// are queued by the stimulus and checked by independent monitors.
module tb_hs_spi_slave_avmm;
    localparam int HALF = 4;

    logic        aclk = 1'b0;
    logic        aresetn, SCK, CSn;
    logic [3:0]  MOSI, MISO;
    logic        MISO_oe, avm_read, avm_write, busy, err_stb;
    logic [9:0]  avm_address;
    logic [31:0] avm_writedata, avm_readdata;
    logic [3:0]  avm_byteenable;
    logic        avm_readdatavalid, avm_waitrequest;

    always #5 aclk = ~aclk;

    hs_spi_slave_avmm #(.AW(10), .DW(32), .SPI_W(4), .DUMMY_CYCLES(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .SCK(SCK), .CSn(CSn), .MOSI(MOSI),
        .MISO(MISO), .MISO_oe(MISO_oe), .avm_address(avm_address),
        .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
        .avm_byteenable(avm_byteenable), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
        .busy(busy), .err_stb(err_stb)
    );

    typedef struct {
        bit          is_wr;
        logic [9:0]  addr;
        logic [31:0] data;
        int          hold;
    } avm_exp_t;

    int          total = 0;
    int          passed = 0;
    avm_exp_t    exp_avm[$];
    logic [31:0] exp_rd[$];
    logic [31:0] act_rd[$];
    int          exp_err_pend = 0;
    logic [31:0] ref_mem   [0:1023];
    logic [31:0] slave_mem [0:1023];
    int          wr_stall = 0;
    int          rd_lat = 2;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Drive point: 2 time units after a rising aclk edge
    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #2;
    endtask

    task automatic beat(input logic [3:0] d, output logic [3:0] q, output logic oe);
        MOSI = d;
        cyc(HALF);
        q  = MISO;
        oe = MISO_oe;
        SCK = 1'b1;
        cyc(HALF);
        SCK = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int nbeats);
        logic [3:0] q;
        logic       oe;
        for (int i = nbeats - 1; i >= 0; i--) beat(v[i*4 +: 4], q, oe);
    endtask

    task automatic end_frame();
        int n;
        CSn = 1'b1;
        n = 0;
        repeat (10) begin
            @(posedge aclk);
            #1;
            n++;
            if (!busy) break;
        end
        chk("busy_fall_latency", 64'(n), 64'd3);
        cyc(16);
    endtask

    task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input int stall, input int ndata);
        wr_stall = stall;
        if (ndata == 8) begin
            exp_avm.push_back('{1'b1, addr, data, stall + 1});
            ref_mem[addr] = data;
        end
        CSn = 1'b0;
        cyc(HALF);
        send_bits(32'h02, 2);
        send_bits({22'd0, addr}, 3);
        if (ndata > 0) send_bits(data >> (4 * (8 - ndata)), ndata);
        end_frame();
    endtask

    task automatic do_read(input logic [9:0] addr, input int lat, input bit late);
        logic [3:0]  q;
        logic        oe;
        logic [31:0] word;
        rd_lat = lat;
        exp_avm.push_back('{1'b0, addr, 32'h0, 1});
        exp_rd.push_back(late ? 32'hFFFF_FFFF : ref_mem[addr]);
        if (late) exp_err_pend++;
        CSn = 1'b0;
        cyc(HALF);
        send_bits(32'h0B, 2);
        send_bits({22'd0, addr}, 3);
        for (int i = 0; i < 4; i++) begin
            beat(4'($urandom), q, oe);
            chk("oe_dummy", 64'(oe), 64'd1);
        end
        word = 32'h0;
        for (int i = 0; i < 8; i++) begin
            beat(4'($urandom), q, oe);
            word = {word[27:0], q};
            chk("oe_rdata", 64'(oe), 64'd1);
        end
        cyc(HALF);
        chk("oe_after_rdata", 64'(MISO_oe), 64'd0);
        act_rd.push_back(word);
        end_frame();
    endtask

    // AVMM responder: stalls writes for wr_stall cycles, returns reads after rd_lat cycles
    initial begin : responder
        int          rd_cnt;
        int          wr_cnt;
        bit          wr_active;
        logic [31:0] rd_word;
        rd_cnt = 0; wr_cnt = 0; wr_active = 1'b0; rd_word = 32'h0;
        avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata = 32'h0;
        forever begin
            @(negedge aclk);
            avm_readdatavalid = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = rd_word;
                end
            end
            if (avm_write) begin
                if (!wr_active) begin
                    wr_active = 1'b1;
                    wr_cnt = wr_stall;
                end
                if (wr_cnt > 0) begin
                    avm_waitrequest = 1'b1;
                    wr_cnt--;
                end else begin
                    avm_waitrequest = 1'b0;
                    slave_mem[avm_address] = avm_writedata;
                    wr_active = 1'b0;
                end
            end else begin
                avm_waitrequest = 1'b0;
                wr_active = 1'b0;
            end
            if (avm_read && !avm_waitrequest) begin
                rd_cnt = rd_lat;
                rd_word = slave_mem[avm_address];
            end
        end
    end

    // AVMM monitor: every accepted access is popped from the expectation queue
    initial begin : avm_monitor
        int          hold;
        bit          stable;
        logic [9:0]  a0;
        logic [31:0] d0;
        avm_exp_t    e;
        hold = 0; stable = 1'b1; a0 = 10'h0; d0 = 32'h0;
        forever begin
            @(negedge aclk);
            #1;
            if (!aresetn) begin
                hold = 0;
            end else if (avm_write || avm_read) begin
                if (hold == 0) begin
                    a0 = avm_address;
                    d0 = avm_writedata;
                    stable = 1'b1;
                end else if ((a0 != avm_address) || (d0 != avm_writedata)) begin
                    stable = 1'b0;
                end
                hold++;
                if (!avm_waitrequest) begin
                    if (exp_avm.size() == 0) begin
                        chk("avm_unexpected_access", 64'd1, 64'd0);
                    end else begin
                        e = exp_avm.pop_front();
                        chk("avm_kind", 64'(avm_write), 64'(e.is_wr));
                        chk("avm_addr", 64'(avm_address), 64'(e.addr));
                        if (e.is_wr) chk("avm_wdata", 64'(avm_writedata), 64'(e.data));
                        chk("avm_hold_cycles", 64'(hold), 64'(e.hold));
                        chk("avm_stable", 64'(stable), 64'd1);
                        chk("avm_byteenable", 64'(avm_byteenable), 64'hF);
                    end
                    hold = 0;
                end
            end
        end
    end

    // Error-pulse monitor: each pulse must match one queued expectation and last one cycle
    initial begin : err_monitor
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge aclk);
            #1;
            if (err_stb) begin
                chk("err_expected", 64'(exp_err_pend > 0), 64'd1);
                chk("err_one_cycle", 64'(prev), 64'd0);
                if (exp_err_pend > 0) exp_err_pend--;
            end
            prev = err_stb;
        end
    end

    // Read-data monitor: words collected by the SPI master against the reference model
    initial begin : rd_monitor
        logic [31:0] a;
        forever begin
            @(negedge aclk);
            while (act_rd.size() > 0) begin
                a = act_rd.pop_front();
                if (exp_rd.size() == 0) chk("rd_unexpected_word", 64'd1, 64'd0);
                else chk("rd_word", 64'(a), 64'(exp_rd.pop_front()));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [3:0] q;
        logic       oe;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i] = $urandom;
            slave_mem[i] = ref_mem[i];
        end
        ref_mem[16]   = 32'h1234_5678;
        slave_mem[16] = 32'h1234_5678;
        aresetn = 1'b0; SCK = 1'b0; CSn = 1'b1; MOSI = 4'h0;
        cyc(3);
        chk("reset_outputs", 64'({MISO, MISO_oe, avm_read, avm_write, avm_address, avm_writedata, busy, err_stb}), 64'd0);
        aresetn = 1'b1;
        cyc(4);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_oe", 64'(MISO_oe), 64'd0);

        do_write(10'h004, 32'hDEAD_BEEF, 0, 8);
        do_read(10'h010, 2, 1'b0);
        do_read(10'h010, 60, 1'b1);

        // Bad command: one error pulse, no AVMM access, MISO never enabled
        exp_err_pend++;
        CSn = 1'b0;
        cyc(HALF);
        beat(4'h5, q, oe); chk("oe_badcmd", 64'(oe), 64'd0);
        beat(4'h5, q, oe); chk("oe_badcmd", 64'(oe), 64'd0);
        for (int i = 0; i < 4; i++) begin
            beat(4'($urandom), q, oe);
            chk("oe_badcmd", 64'(oe), 64'd0);
        end
        end_frame();

        // Stalled write; CSn rises while waitrequest is still high
        do_write(10'h123, 32'hA5C3_0F96, 5, 8);
        do_read(10'h123, 2, 1'b0);

        // Mid-frame abort after one data beat, then a normal frame
        do_write(10'h055, 32'h1111_2222, 0, 1);
        do_write(10'h055, 32'h3333_4444, 0, 8);
        do_read(10'h055, 3, 1'b0);

        // Reset in the middle of a read frame
        rd_lat = 2;
        exp_avm.push_back('{1'b0, 10'h004, 32'h0, 1});
        CSn = 1'b0;
        cyc(HALF);
        send_bits(32'h0B, 2);
        send_bits(32'h004, 3);
        beat(4'h0, q, oe);
        aresetn = 1'b0;
        #1;
        chk("reset_mid_read", 64'({MISO, MISO_oe, avm_read, avm_write, avm_address, avm_writedata, busy, err_stb}), 64'd0);
        CSn = 1'b1; SCK = 1'b0;
        cyc(5);
        aresetn = 1'b1;
        cyc(4);
        do_read(10'h004, 2, 1'b0);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 0) do_write(10'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3), 8);
            else do_read(10'($urandom_range(0, 15)), $urandom_range(1, 4), 1'b0);
        end

        cyc(80);
        chk("avm_queue_drained", 64'(exp_avm.size()), 64'd0);
        chk("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
        chk("err_queue_drained", 64'(exp_err_pend), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hs_spi_slave_avmm.md
Name: hs_spi_slave_avmm

Overview:
- Quad-lane SPI responder: the far-end counterpart of the team's hs_spi master.
- Decodes command/address/data frames on SCK/CSn/MOSI.
- Issues single-beat AVMM reads and writes into a local register space; returns read data on MISO after a fixed dummy gap.
- Single-clock design: SPI pins are oversampled in aclk, so aclk must be at least 8x SCK.

Parameters:
AW, 10, AVMM address width (word address)
DW, 32, data width; must be a multiple of SPI_W
SPI_W, 4, number of data lanes
DUMMY_CYCLES, 4, SCK cycles between the last address beat and the first read-data beat

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous reset, active low
SCK  in  1  SPI clock; idles low (mode 0)
CSn  in  1  chip select, active low
MOSI  in  SPI_W  command/address/write data, MSB lane first
MISO  out  SPI_W  read data
MISO_oe  out  1  MISO output enable
avm_address  out  AW  AVMM word address
avm_read  out  1  read request
avm_write  out  1  write request
avm_writedata  out  DW  write data
avm_byteenable  out  DW/8  always all ones
avm_readdata  in  DW  read data
avm_readdatavalid  in  1  read data valid
avm_waitrequest  in  1  stall
busy  out  1  high from CSn fall until return to IDLE
err_stb  out  1  one-cycle pulse on an error

Behaviour:
- Reset values: MISO=0, MISO_oe=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, busy=0, err_stb=0; FSM=IDLE.
- Input synchronisation: SCK, CSn and MOSI each pass through a 2-FF synchronizer.
- Edge detection: rise = sck_s & ~sck_d; fall = ~sck_s & sck_d.
- MOSI is sampled on rise only.
- Frame format, all fields MSB first, SPI_W bits per SCK:
  - CMD: 8 bits. 0x02 = write, 0x0B = read.
  - ADDR: AF = SPI_W*ceil(AW/SPI_W) bits. Only the low AW bits are used; upper bits are ignored.
  - Write frames then carry DATA of DW bits.
  - Read frames then carry DUMMY_CYCLES SCK cycles of dummy, followed by DW bits driven by the slave.
- A shared beat counter counts SCK rises within the current field.
- FSM:
  - IDLE: CSn falling (synced) -> CMD, busy=1.
  - CMD: after 8/SPI_W rises, decode the command. 0x02/0x0B -> ADDR. Any other value -> IGNORE and err_stb pulse.
  - ADDR: after AF/SPI_W rises, latch avm_address. Write -> WDATA. Read -> assert avm_read on the next cycle and go to RDUMMY.
  - WDATA: after DW/SPI_W rises -> WRITE with avm_write=1.
  - WRITE: hold avm_write until a cycle with waitrequest=0, then -> IGNORE.
  - RDUMMY:
    - Deassert avm_read on the first cycle in which avm_read=1 and waitrequest=0.
    - Capture avm_readdata into the shift register when readdatavalid=1.
    - MISO_oe=1 from entry.
    - On the fall following the DUMMY_CYCLES-th rise -> RDATA.
    - If no data has been captured by then: load all-ones and pulse err_stb.
  - RDATA: on each fall, present the next SPI_W bits on MISO; the first nibble goes out on that entry fall. After DW/SPI_W falls -> IGNORE.
  - IGNORE: MISO_oe=0; wait for CSn high.
- CSn high (synced) in any state -> IDLE next cycle, busy=0, MISO_oe=0. This is the mid-frame abort rule.
  - A WRITE already asserted still holds avm_write until waitrequest=0; AVMM protocol cannot be dropped.
  - A short write frame issues no write.
  - An outstanding read still consumes its readdatavalid; that data is discarded.
- Extra SCK rises after the frame (IGNORE) have no effect.
- Exactly one AVMM access per frame. No bursts and no address auto-increment.
- Latency:
  - avm_write asserts 1 aclk after the synchronized rise of the last data beat.
  - avm_read asserts 1 aclk after the synchronized rise of the last address beat.
- Simultaneous CSn rise and SCK rise in the same cycle: CSn wins and that beat is not sampled.

Test Plan:
- Write: CSn low; send 0x02, addr 0x004, data 0xDEADBEEF at aclk/8 -> one avm_write pulse with address=0x004, writedata=0xDEADBEEF, byteenable=4'hF; busy falls 3 cycles after CSn rises.
- Read: send 0x0B, addr 0x010; model returns 0x12345678 two cycles after avm_read; 4 dummy cycles, 8 data cycles -> MISO nibbles 1,2,3,4,5,6,7,8; MISO_oe=1 from dummy until IGNORE; err_stb=0.
- Late read data: readdatavalid arrives after the dummy window -> MISO all 0xF for 8 beats, err_stb one pulse, late data ignored.
- Bad command 0x55 -> err_stb pulse after the 2nd SCK; no avm_read/avm_write; MISO_oe=0 for the whole frame.
- Waitrequest held 5 cycles on a write -> avm_write held high 6 cycles with stable address/data. CSn raised during that wait -> write still completes once.
- Abort: CSn high after 1 write-data beat -> no AVMM access; FSM in IDLE; next frame is decoded normally. aresetn low mid-read -> all outputs 0 immediately.
